// File: rtl/wm8731_cfg_sequencer.sv
// WM8731 register-write sequencer: walks the codec init table, then forwards
// single runtime writes, all through one shared I2C master.
module wm8731_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         GAP_CYCLES = 500,
  parameter int         MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        wr_req,
  input  logic [6:0]  wr_reg,
  input  logic [8:0]  wr_data,
  output logic        wr_ack,
  output logic        i2c_start,
  output logic [23:0] i2c_word,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]    state;
  logic [3:0]    index;
  logic [RW-1:0] retry;
  logic [GW-1:0] gap_cnt;
  logic          rt;
  logic          pend;

  // {reg[6:0], data[8:0]} per init step; the final entry activates the codec
  function automatic logic [15:0] entry(input logic [3:0] i);
    case (i)
      4'd0:    entry = {7'd15, 9'h000};
      4'd1:    entry = {7'd0,  9'h017};
      4'd2:    entry = {7'd1,  9'h017};
      4'd3:    entry = {7'd2,  9'h079};
      4'd4:    entry = {7'd3,  9'h079};
      4'd5:    entry = {7'd4,  9'h012};
      4'd6:    entry = {7'd5,  9'h000};
      4'd7:    entry = {7'd6,  9'h000};
      4'd8:    entry = {7'd7,  9'h00A};
      4'd9:    entry = {7'd8,  9'h000};
      default: entry = {7'd9,  9'h001};
    endcase
  endfunction

  assign busy = !(state == S_IDLE || state == S_DONE || state == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      index     <= '0;
      retry     <= '0;
      gap_cnt   <= '0;
      rt        <= 1'b0;
      pend      <= 1'b0;
      i2c_word  <= '0;
      i2c_start <= 1'b0;
      wr_ack    <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      i2c_start <= 1'b0;
      wr_ack    <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (cfg_start) begin
            state     <= S_LOAD;
            index     <= '0;
            retry     <= '0;
            pend      <= 1'b0;
            rt        <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
          end else if (state == S_DONE && wr_req && !wr_ack) begin
            // the wr_ack cycle still sees the old request level
            state <= S_LOAD;
            rt    <= 1'b1;
            retry <= '0;
            pend  <= 1'b0;
          end
        end
        S_LOAD: begin
          i2c_word <= rt ? {DEV_ADDR, wr_reg, wr_data}
                         : {DEV_ADDR, entry(index)};
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!i2c_busy) begin
            i2c_start <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i2c_done) begin
            if (!i2c_nack) begin
              retry   <= '0;
              pend    <= 1'b0;
              gap_cnt <= '0;
              state   <= S_GAP;
            end else if (retry < RW'(MAX_RETRY)) begin
              retry   <= retry + RW'(1);
              pend    <= 1'b1;
              gap_cnt <= '0;
              state   <= S_GAP;
            end else if (rt) begin
              retry     <= '0;
              cfg_error <= 1'b1;
              state     <= S_DONE;
            end else begin
              retry     <= '0;
              cfg_error <= 1'b1;
              cfg_done  <= 1'b0;
              state     <= S_ERR;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            if (pend) begin
              pend  <= 1'b0;
              state <= S_LOAD;
            end else if (rt) begin
              wr_ack <= 1'b1;
              state  <= S_DONE;
            end else if (index == 4'd10) begin
              cfg_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              index <= index + 4'd1;
              state <= S_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_cfg_sequencer.sv
// Bench for wm8731_cfg_sequencer: a behavioural I2C master answers frames
// with planned ACK/NACK and the observed frames are compared to a table model.
module tb_wm8731_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        wr_req = 1'b0;
  logic [6:0]  wr_reg = '0;
  logic [8:0]  wr_data = '0;
  logic        wr_ack;
  logic        i2c_start;
  logic [23:0] i2c_word;
  logic        i2c_busy;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        busy;
  logic        cfg_done;
  logic        cfg_error;

  logic resp_busy = 1'b0;
  logic hold_busy = 1'b0;
  assign i2c_busy = resp_busy | hold_busy;

  wm8731_cfg_sequencer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .wr_req(wr_req), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_ack(wr_ack), .i2c_start(i2c_start), .i2c_word(i2c_word),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [23:0] starts[$];
  int          start_cyc[$];
  int          done_cyc[$];
  bit          nack_q[$];
  int          unstable = 0;
  int          ack_cnt = 0;
  int          ack_cyc = 0;

  int t_reg[11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int t_dat[11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                    'h000, 'h000, 'h00A, 'h000, 'h001};

  function automatic logic [23:0] frame(int r, int d);
    return 24'(('h34 << 16) + (r << 9) + d);
  endfunction

  // I2C master model
  initial begin
    logic [23:0] w;
    int lat;
    bit aborted;
    forever begin
      @(negedge clk);
      if (i2c_done) begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        resp_busy = 1'b0;
      end else if (i2c_start && !rst) begin
        starts.push_back(i2c_word);
        start_cyc.push_back(cyc);
        w = i2c_word;
        resp_busy = 1'b1;
        lat = $urandom_range(2, 8);
        aborted = 0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          if (i2c_word !== w) unstable++;
        end
        if (aborted) begin
          resp_busy = 1'b0;
        end else begin
          i2c_done = 1'b1;
          i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (wr_ack === 1'b1) begin
        ack_cnt++;
        ack_cyc = cyc;
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log;
    starts.delete();
    start_cyc.delete();
    done_cyc.delete();
    nack_q.delete();
    unstable = 0;
    ack_cnt = 0;
  endtask

  task automatic pulse_start(output int c);
    step();
    cfg_start = 1'b1;
    c = cyc;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (ack_cnt > 0) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset;
    logic [29:0] outs;
    rst = 1'b1;
    repeat (3) step();
    outs = {wr_ack, i2c_start, i2c_word, busy, cfg_done, cfg_error};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    rst = 1'b0;
    repeat (50) step();
    checks++;
    if (starts.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: starts %0d busy %b want 0 0",
               starts.size(), busy);
    end
  endtask

  task automatic test_init_ack;
    int c;
    bit ok;
    clear_log();
    pulse_start(c);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init_timeout: busy stuck");
    end
    checks++;
    if (starts.size() != 11) begin
      errors++;
      $display("FAIL init_count: got %0d want 11", starts.size());
    end
    for (int i = 0; i < 11 && i < starts.size(); i++) begin
      checks++;
      if (starts[i] !== frame(t_reg[i], t_dat[i])) begin
        errors++;
        $display("FAIL init_word[%0d]: got %h want %h",
                 i, starts[i], frame(t_reg[i], t_dat[i]));
      end
    end
    checks++;
    if (starts.size() > 0 && start_cyc[0] - c != 3) begin
      errors++;
      $display("FAIL init_latency: got %0d want 3", start_cyc[0] - c);
    end
    for (int i = 1; i < starts.size() && i <= done_cyc.size(); i++) begin
      checks++;
      if (start_cyc[i] - done_cyc[i-1] < 500) begin
        errors++;
        $display("FAIL init_gap[%0d]: got %0d want >=500",
                 i, start_cyc[i] - done_cyc[i-1]);
      end
    end
    checks++;
    if (cfg_done !== 1'b1 || busy !== 1'b0 || cfg_error !== 1'b0
        || unstable != 0) begin
      errors++;
      $display("FAIL init_flags: done %b busy %b err %b unst %0d want 1 0 0 0",
               cfg_done, busy, cfg_error, unstable);
    end
  endtask

  task automatic test_nack_retry;
    int c, k, n;
    bit ok;
    logic [23:0] exp_q[$];
    for (int it = 0; it < 2; it++) begin
      k = (it == 0) ? 3 : $urandom_range(0, 10);
      n = (it == 0) ? 2 : $urandom_range(1, 3);
      clear_log();
      exp_q.delete();
      for (int i = 0; i < k; i++) nack_q.push_back(1'b0);
      for (int i = 0; i < n; i++) nack_q.push_back(1'b1);
      for (int i = 0; i < 11; i++)
        for (int r = 0; r < ((i == k) ? n + 1 : 1); r++)
          exp_q.push_back(frame(t_reg[i], t_dat[i]));
      pulse_start(c);
      wait_idle(ok);
      checks++;
      if (!ok || starts.size() != exp_q.size()) begin
        errors++;
        $display("FAIL retry_count k=%0d n=%0d: got %0d want %0d",
                 k, n, starts.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < starts.size(); i++) begin
        checks++;
        if (starts[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL retry_word[%0d]: got %h want %h",
                   i, starts[i], exp_q[i]);
        end
      end
      checks++;
      if (cfg_error !== 1'b0 || cfg_done !== 1'b1) begin
        errors++;
        $display("FAIL retry_flags: err %b done %b want 0 1",
                 cfg_error, cfg_done);
      end
    end
  endtask

  task automatic test_nack_exhaust;
    int c;
    bit ok;
    logic [23:0] exp_q[$];
    clear_log();
    for (int i = 0; i < 5; i++) nack_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) nack_q.push_back(1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(frame(t_reg[i], t_dat[i]));
    for (int i = 0; i < 4; i++) exp_q.push_back(frame(t_reg[5], t_dat[5]));
    pulse_start(c);
    wait_idle(ok);
    wr_req = 1'b1;
    wr_reg = 7'($urandom);
    wr_data = 9'($urandom);
    repeat (600) step();
    wr_req = 1'b0;
    checks++;
    if (!ok || starts.size() != 9 || ack_cnt != 0) begin
      errors++;
      $display("FAIL exhaust_count: got %0d acks %0d want 9 0",
               starts.size(), ack_cnt);
    end
    for (int i = 0; i < 9 && i < starts.size(); i++) begin
      checks++;
      if (starts[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL exhaust_word[%0d]: got %h want %h",
                 i, starts[i], exp_q[i]);
      end
    end
    checks++;
    if (cfg_error !== 1'b1 || cfg_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_flags: err %b done %b busy %b want 1 0 0",
               cfg_error, cfg_done, busy);
    end
  endtask

  task automatic test_runtime;
    int c, r, d;
    bit ok;
    clear_log();
    pulse_start(c);
    wait_idle(ok);
    checks++;
    if (!ok || cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL rt_init: done %b err %b want 1 0", cfg_done, cfg_error);
    end
    for (int it = 0; it < 3; it++) begin
      clear_log();
      r = (it == 0) ? 2 : $urandom_range(0, 127);
      d = (it == 0) ? 'h065 : $urandom_range(0, 511);
      if (it == 2) nack_q.push_back(1'b1);
      wr_reg = 7'(r);
      wr_data = 9'(d);
      wr_req = 1'b1;
      wait_ack(ok);
      wr_req = 1'b0;
      repeat (20) step();
      checks++;
      if (!ok || ack_cnt != 1) begin
        errors++;
        $display("FAIL rt_ack[%0d]: got %0d pulses want 1", it, ack_cnt);
      end
      checks++;
      if (starts.size() != ((it == 2) ? 2 : 1)) begin
        errors++;
        $display("FAIL rt_count[%0d]: got %0d want %0d",
                 it, starts.size(), (it == 2) ? 2 : 1);
      end
      for (int i = 0; i < starts.size(); i++) begin
        checks++;
        if (starts[i] !== frame(r, d)) begin
          errors++;
          $display("FAIL rt_word[%0d.%0d]: got %h want %h",
                   it, i, starts[i], frame(r, d));
        end
      end
      checks++;
      if (done_cyc.size() > 0 && ack_cyc - done_cyc[done_cyc.size()-1] < 500) begin
        errors++;
        $display("FAIL rt_gap[%0d]: got %0d want >=500",
                 it, ack_cyc - done_cyc[done_cyc.size()-1]);
      end
    end
    checks++;
    if (cfg_error !== 1'b0 || cfg_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rt_flags: err %b done %b busy %b want 0 1 0",
               cfg_error, cfg_done, busy);
    end
  endtask

  task automatic test_busy_hold;
    int r, d, rel;
    bit ok;
    clear_log();
    r = $urandom_range(0, 127);
    d = $urandom_range(0, 511);
    hold_busy = 1'b1;
    wr_reg = 7'(r);
    wr_data = 9'(d);
    wr_req = 1'b1;
    repeat (20) step();
    checks++;
    if (starts.size() != 0 || busy !== 1'b1 || i2c_word !== frame(r, d)) begin
      errors++;
      $display("FAIL hold_wait: starts %0d busy %b word %h want 0 1 %h",
               starts.size(), busy, i2c_word, frame(r, d));
    end
    rel = cyc;
    hold_busy = 1'b0;
    wait_ack(ok);
    wr_req = 1'b0;
    step();
    checks++;
    if (!ok || starts.size() != 1) begin
      errors++;
      $display("FAIL hold_count: got %0d want 1", starts.size());
    end
    checks++;
    if (starts.size() > 0 &&
        (starts[0] !== frame(r, d) || start_cyc[0] - rel > 2)) begin
      errors++;
      $display("FAIL hold_start: word %h delay %0d want %h <=2",
               starts[0], start_cyc[0] - rel, frame(r, d));
    end
  endtask

  task automatic test_reset_mid;
    int c;
    bit ok;
    logic [29:0] outs;
    clear_log();
    pulse_start(c);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (starts.size() >= 7) begin
        ok = 1;
        break;
      end
      step();
    end
    rst = 1'b1;
    #1;
    outs = {wr_ack, i2c_start, i2c_word, busy, cfg_done, cfg_error};
    checks++;
    if (!ok || outs !== '0) begin
      errors++;
      $display("FAIL midrst_outs: got %h want 0", outs);
    end
    step();
    rst = 1'b0;
    repeat (100) step();
    checks++;
    if (starts.size() != 7) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d starts want 7", starts.size());
    end
    pulse_start(c);
    for (int i = 0; i < 100 && starts.size() < 8; i++) step();
    checks++;
    if (starts.size() < 8 || starts[7] !== 24'h341E00) begin
      errors++;
      $display("FAIL midrst_restart: got %h want 341e00",
               (starts.size() < 8) ? 24'h0 : starts[7]);
    end
    wait_idle(ok);
    checks++;
    if (!ok || cfg_done !== 1'b1 || starts.size() != 18) begin
      errors++;
      $display("FAIL midrst_done: done %b starts %0d want 1 18",
               cfg_done, starts.size());
    end
  endtask

  initial begin
    test_reset();
    test_init_ack();
    test_nack_retry();
    test_nack_exhaust();
    test_runtime();
    test_busy_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
